// File: rtl/id_ex_decoder_pkg.sv
// id_ex_decoder_pkg: opcodes, ALU one-hot bit indices, FSM states, field offsets and the ID/EX entry type (illegal field only with DECODE_ILLEGAL_TRAP_EN)
package id_ex_decoder_pkg;
  localparam int OPW = 5;
  localparam int REGW = 3;
  localparam int DATAW = 16;
  localparam int SHW = 4;
  localparam int ALUW = 13;
  localparam int OP_LSB = 11;
  localparam int RDST_LSB = 8;
  localparam int RSRC_LSB = 5;
  localparam int SHAMT_LSB = 1;
  localparam logic [OPW-1:0] OPC_NOP = 5'h00;
  localparam logic [OPW-1:0] OPC_NOT = 5'h01;
  localparam logic [OPW-1:0] OPC_INC = 5'h02;
  localparam logic [OPW-1:0] OPC_DEC = 5'h03;
  localparam logic [OPW-1:0] OPC_OUT = 5'h04;
  localparam logic [OPW-1:0] OPC_IN  = 5'h05;
  localparam logic [OPW-1:0] OPC_MOV = 5'h08;
  localparam logic [OPW-1:0] OPC_ADD = 5'h09;
  localparam logic [OPW-1:0] OPC_SUB = 5'h0A;
  localparam logic [OPW-1:0] OPC_AND = 5'h0B;
  localparam logic [OPW-1:0] OPC_OR  = 5'h0C;
  localparam logic [OPW-1:0] OPC_SHL = 5'h0D;
  localparam logic [OPW-1:0] OPC_SHR = 5'h0E;
  localparam logic [OPW-1:0] OPC_LDM = 5'h10;
  localparam int OP_OUT = 12;
  localparam int OP_IN  = 11;
  localparam int OP_NOP = 10;
  localparam int OP_NOT = 9;
  localparam int OP_INC = 8;
  localparam int OP_DEC = 7;
  localparam int OP_MOV = 6;
  localparam int OP_ADD = 5;
  localparam int OP_SUB = 4;
  localparam int OP_AND = 3;
  localparam int OP_OR  = 2;
  localparam int OP_SHL = 1;
  localparam int OP_SHR = 0;
  typedef enum logic {S_OP = 1'b0, S_IMM = 1'b1} state_t;
  typedef struct packed {
    logic [ALUW-1:0]  alu_operation;
    logic [SHW-1:0]   shamt;
    logic [REGW-1:0]  rdst;
    logic [REGW-1:0]  rsrc;
    logic [DATAW-1:0] imm;
    logic             use_imm;
    logic             reg_write;
    logic             valid;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic             illegal;
`endif
  } idex_t;
  function automatic logic [ALUW-1:0] bit_of(input int b);
    bit_of = '0;
    bit_of[b] = 1'b1;
  endfunction
endpackage

// File: rtl/id_ex_decoder_opcode_onehot_dec.sv
// opcode_onehot_dec: opcode to 13-bit ALU one-hot, reg_write, is_ldm (illegal output with DECODE_ILLEGAL_TRAP_EN)
module opcode_onehot_dec
  import id_ex_decoder_pkg::*;
(
  input  logic [OPW-1:0]  op,
  output logic [ALUW-1:0] onehot,
  output logic            reg_write,
  output logic            is_ldm
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic            illegal
`endif
);
  always_comb begin
    onehot = bit_of(OP_NOP);
    reg_write = 1'b1;
    is_ldm = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
    illegal = 1'b0;
`endif
    case (op)
      OPC_NOP: reg_write = 1'b0;
      OPC_NOT: onehot = bit_of(OP_NOT);
      OPC_INC: onehot = bit_of(OP_INC);
      OPC_DEC: onehot = bit_of(OP_DEC);
      OPC_OUT: begin
        onehot = bit_of(OP_OUT);
        reg_write = 1'b0;
      end
      OPC_IN:  onehot = bit_of(OP_IN);
      OPC_MOV: onehot = bit_of(OP_MOV);
      OPC_ADD: onehot = bit_of(OP_ADD);
      OPC_SUB: onehot = bit_of(OP_SUB);
      OPC_AND: onehot = bit_of(OP_AND);
      OPC_OR:  onehot = bit_of(OP_OR);
      OPC_SHL: onehot = bit_of(OP_SHL);
      OPC_SHR: onehot = bit_of(OP_SHR);
      OPC_LDM: begin
        is_ldm = 1'b1;
        reg_write = 1'b0;
      end
      default: begin
        reg_write = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
        illegal = 1'b1;
`endif
      end
    endcase
  end
endmodule

// File: rtl/id_ex_decoder.sv
// id_ex_decoder: decode stage with LDM two-word FSM and ID/EX register; DECODE_ILLEGAL_TRAP_EN adds illegal_op
module id_ex_decoder
  import id_ex_decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [DATAW-1:0] instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             stall,
  input  logic             flush,
  output logic [ALUW-1:0]  alu_operation,
  output logic [SHW-1:0]   shamt,
  output logic [REGW-1:0]  rdst,
  output logic [REGW-1:0]  rsrc,
  output logic [DATAW-1:0] imm,
  output logic             use_imm,
  output logic             reg_write,
  output logic             valid_out
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic             illegal_op
`endif
);
  logic [ALUW-1:0] onehot;
  logic            dec_rw;
  logic            is_ldm;
  logic            accept;
  logic            is_shift;
  logic [REGW-1:0] ldm_rdst_q;
  state_t          state_q;
  state_t          state_d;
  idex_t           idex_q;
  idex_t           idex_d;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic            dec_ill;
`endif
  opcode_onehot_dec u_dec (
    .op        (instr[OP_LSB +: OPW]),
    .onehot    (onehot),
    .reg_write (dec_rw),
    .is_ldm    (is_ldm)
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    .illegal   (dec_ill)
`endif
  );
  assign accept = instr_valid && !stall;
  assign is_shift = onehot[OP_SHL] | onehot[OP_SHR];
  assign instr_ready = !stall;
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_OP;
    else state_q <= state_d;
  end
  always_comb state_d = flush ? S_OP : !accept ? state_q : (state_q == S_OP && is_ldm) ? S_IMM : S_OP;
  always_ff @(posedge clk) begin
    if (rst) ldm_rdst_q <= '0;
    else if (accept && state_q == S_OP && is_ldm) ldm_rdst_q <= instr[RDST_LSB +: REGW];
  end
  always_comb begin
    idex_d = '0;
    idex_d.alu_operation = bit_of(OP_NOP);
    if (flush) idex_d = '0;
    else if (stall) idex_d = idex_q;
    else if (instr_valid && state_q == S_IMM) begin
      idex_d.alu_operation = bit_of(OP_MOV);
      idex_d.rdst = ldm_rdst_q;
      idex_d.imm = instr;
      idex_d.use_imm = 1'b1;
      idex_d.reg_write = 1'b1;
      idex_d.valid = 1'b1;
    end else if (instr_valid && !is_ldm) begin
      idex_d.alu_operation = onehot;
      idex_d.shamt = is_shift ? instr[SHAMT_LSB +: SHW] : '0;
      idex_d.rdst = instr[RDST_LSB +: REGW];
      idex_d.rsrc = instr[RSRC_LSB +: REGW];
      idex_d.reg_write = dec_rw;
      idex_d.valid = 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
      idex_d.illegal = dec_ill;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) idex_q <= '0;
    else idex_q <= idex_d;
  end
  assign alu_operation = idex_q.alu_operation;
  assign shamt = idex_q.shamt;
  assign rdst = idex_q.rdst;
  assign rsrc = idex_q.rsrc;
  assign imm = idex_q.imm;
  assign use_imm = idex_q.use_imm;
  assign reg_write = idex_q.reg_write;
  assign valid_out = idex_q.valid;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign illegal_op = idex_q.illegal;
`endif
endmodule

// File: tb/tb_id_ex_decoder.sv
// tb_id_ex_decoder: directed vectors with a behavioural model and per-cycle compare for id_ex_decoder
module tb_id_ex_decoder;
  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        stall;
  logic        flush;
  logic [12:0] alu_operation;
  logic [3:0]  shamt;
  logic [2:0]  rdst;
  logic [2:0]  rsrc;
  logic [15:0] imm;
  logic        use_imm;
  logic        reg_write;
  logic        valid_out;
  logic        illegal_op;
  int          n_tests = 0;
  int          n_fail = 0;
  logic        started = 1'b0;
  id_ex_decoder dut (
    .clk           (clk),
    .rst           (rst),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .stall         (stall),
    .flush         (flush),
    .alu_operation (alu_operation),
    .shamt         (shamt),
    .rdst          (rdst),
    .rsrc          (rsrc),
    .imm           (imm),
    .use_imm       (use_imm),
    .reg_write     (reg_write),
    .valid_out     (valid_out)
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    .illegal_op    (illegal_op)
`endif
  );
`ifndef DECODE_ILLEGAL_TRAP_EN
  assign illegal_op = 1'b0;
`endif
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  typedef struct packed {
    logic [12:0] alu;
    logic [3:0]  sh;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [15:0] im;
    logic        ui;
    logic        rw;
    logic        v;
    logic        ill;
  } o_t;
  // Opcode table: ALU bit index, -1 undefined, -2 LDM
  int tbl [32];
  initial begin
    for (int i = 0; i < 32; i++) tbl[i] = -1;
    tbl[5'h00] = 10; tbl[5'h01] = 9; tbl[5'h02] = 8; tbl[5'h03] = 7;
    tbl[5'h04] = 12; tbl[5'h05] = 11; tbl[5'h08] = 6; tbl[5'h09] = 5;
    tbl[5'h0A] = 4; tbl[5'h0B] = 3; tbl[5'h0C] = 2; tbl[5'h0D] = 1;
    tbl[5'h0E] = 0; tbl[5'h10] = -2;
  end
  function automatic o_t bubble();
    o_t o = '0;
    o.alu[10] = 1'b1;
    return o;
  endfunction
  function automatic o_t single(input logic [15:0] w);
    o_t o = '0;
    int b = tbl[w[15:11]];
    o.alu[b < 0 ? 10 : b] = 1'b1;
    o.sh = (b == 0 || b == 1) ? w[4:1] : 4'd0;
    o.rd = w[10:8];
    o.rs = w[7:5];
    o.rw = (b >= 0) && (b != 10) && (b != 12);
    o.v = 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
    o.ill = (b == -1);
`endif
    return o;
  endfunction
  function automatic o_t imm_word(input logic [2:0] r, input logic [15:0] w);
    o_t o = '0;
    o.alu[6] = 1'b1;
    o.rd = r;
    o.im = w;
    o.ui = 1'b1;
    o.rw = 1'b1;
    o.v = 1'b1;
    return o;
  endfunction
  o_t          exp_o;
  logic        pend;
  logic [2:0]  prd;
  always @(posedge clk) begin
    if (rst || flush) begin
      exp_o <= '0;
      pend <= 1'b0;
    end else if (!stall) begin
      if (!instr_valid) exp_o <= bubble();
      else if (pend) begin
        exp_o <= imm_word(prd, instr);
        pend <= 1'b0;
      end else if (tbl[instr[15:11]] == -2) begin
        exp_o <= bubble();
        pend <= 1'b1;
        prd <= instr[10:8];
      end else exp_o <= single(instr);
    end
  end
  o_t act_o;
  assign act_o = '{alu: alu_operation, sh: shamt, rd: rdst, rs: rsrc, im: imm, ui: use_imm, rw: reg_write, v: valid_out, ill: illegal_op};
  always @(negedge clk) begin
    if (started) begin
      n_tests++;
      if (act_o !== exp_o) begin
        n_fail++;
        $display("FAIL model t=%0t got alu=%h sh=%h rd=%0d rs=%0d imm=%h ui=%b rw=%b v=%b ill=%b want alu=%h sh=%h rd=%0d rs=%0d imm=%h ui=%b rw=%b v=%b ill=%b",
                 $time, act_o.alu, act_o.sh, act_o.rd, act_o.rs, act_o.im, act_o.ui, act_o.rw, act_o.v, act_o.ill,
                 exp_o.alu, exp_o.sh, exp_o.rd, exp_o.rs, exp_o.im, exp_o.ui, exp_o.rw, exp_o.v, exp_o.ill);
      end
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask
  task automatic cyc(input logic r, input logic v, input logic [15:0] w, input logic s, input logic f);
    rst = r;
    instr_valid = v;
    instr = w;
    stall = s;
    flush = f;
    #1;
    chk("instr_ready", 64'(instr_ready), 64'(!s));
    @(negedge clk);
  endtask
  initial begin
    cyc(1, 0, 16'h0000, 0, 0);
    started = 1'b1;
    cyc(1, 1, 16'h4A40, 0, 1);
    chk("reset_all_zero", 64'(act_o), 64'd0);
    chk("reset_alu", 64'(alu_operation), 64'h0);
    cyc(0, 1, 16'h4A40, 0, 0);
    chk("add_alu", 64'(alu_operation), 64'h0020);
    chk("add_rdst", 64'(rdst), 64'd2);
    chk("add_rsrc", 64'(rsrc), 64'd2);
    chk("add_valid", 64'(valid_out), 64'd1);
    chk("add_rw", 64'(reg_write), 64'd1);
    cyc(0, 1, 16'h6B0A, 0, 0);
    chk("shl_alu", 64'(alu_operation), 64'h0002);
    chk("shl_shamt", 64'(shamt), 64'd5);
    chk("shl_rdst", 64'(rdst), 64'd3);
    cyc(0, 1, 16'h8400, 0, 0);
    chk("ldm_bubble_valid", 64'(valid_out), 64'd0);
    chk("ldm_bubble_alu", 64'(alu_operation), 64'h0400);
    cyc(0, 1, 16'hBEEF, 0, 0);
    chk("ldm_mov_alu", 64'(alu_operation), 64'h0040);
    chk("ldm_imm", 64'(imm), 64'hBEEF);
    chk("ldm_use_imm", 64'(use_imm), 64'd1);
    chk("ldm_rdst", 64'(rdst), 64'd4);
    chk("ldm_rw", 64'(reg_write), 64'd1);
    cyc(0, 1, 16'h8400, 0, 0);
    cyc(0, 1, 16'h1234, 1, 1);
    chk("flush_valid", 64'(valid_out), 64'd0);
    chk("flush_alu", 64'(alu_operation), 64'h0);
    cyc(0, 1, 16'h0800, 0, 0);
    chk("post_flush_not", 64'(alu_operation), 64'h0200);
    chk("post_flush_valid", 64'(valid_out), 64'd1);
    cyc(0, 1, 16'h4A40, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 16'h5000 + 16'(i), 1, 0);
      chk("stall_hold_alu", 64'(alu_operation), 64'h0020);
    end
    cyc(0, 1, 16'hF800, 0, 0);
    chk("undef_alu", 64'(alu_operation), 64'h0400);
    chk("undef_rw", 64'(reg_write), 64'd0);
    chk("undef_valid", 64'(valid_out), 64'd1);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("undef_illegal", 64'(illegal_op), 64'd1);
`endif
    cyc(0, 0, 16'h4A40, 0, 0);
    chk("idle_bubble", 64'(alu_operation), 64'h0400);
    chk("idle_valid", 64'(valid_out), 64'd0);
    cyc(0, 1, 16'h711E, 0, 0);
    chk("shr_alu", 64'(alu_operation), 64'h0001);
    chk("shr_shamt", 64'(shamt), 64'hF);
    cyc(0, 1, 16'h401E, 0, 0);
    chk("mov_shamt_zero", 64'(shamt), 64'd0);
    cyc(0, 1, 16'h2000, 0, 0);
    chk("out_alu", 64'(alu_operation), 64'h1000);
    chk("out_rw", 64'(reg_write), 64'd0);
    cyc(0, 1, 16'h8700, 0, 0);
    cyc(0, 0, 16'h0800, 0, 0);
    cyc(0, 1, 16'h1234, 1, 0);
    cyc(0, 1, 16'h1234, 0, 0);
    chk("ldm_gap_alu", 64'(alu_operation), 64'h0040);
    chk("ldm_gap_imm", 64'(imm), 64'h1234);
    chk("ldm_gap_rdst", 64'(rdst), 64'd7);
    cyc(0, 1, 16'h8100, 0, 0);
    cyc(1, 1, 16'h0800, 0, 1);
    chk("rst_over_flush", 64'(act_o), 64'd0);
    cyc(0, 1, 16'h0800, 0, 0);
    chk("rst_clears_ldm", 64'(alu_operation), 64'h0200);
    for (int op = 0; op < 32; op++) begin
      cyc(0, 1, {5'(op), 11'h5A7}, 0, 0);
      if (op == 16) cyc(0, 1, 16'hC3C3, 0, 0);
    end
    cyc(0, 0, 16'h0000, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
